// File: rtl/tree_plru_pkg.sv
// ---------------------------------------------------------------------------
// tree_plru_pkg
// Shared types and helper functions for the tree pseudo-LRU engine.
// The functions work on a fixed maximum-width tree (32 ways, 31 nodes) and
// take the real way count as an argument, so one set of helpers serves every
// legal WAYS setting. Callers zero-extend narrower trees and one-hot vectors.
//   plru_victim : walk from the root following the node bits, return leaf index
//   plru_update : point every node on a way's path away from that way
//   onehot2idx  : one-hot vector to index, with a "exactly one bit set" flag
// ---------------------------------------------------------------------------
package tree_plru_pkg;

    localparam int MAX_WAYS   = 32;
    localparam int MAX_LEVELS = 5;
    localparam int MAX_NODES  = MAX_WAYS - 1;

    typedef logic [MAX_NODES-1:0]  tree_t;
    typedef logic [MAX_LEVELS-1:0] way_idx_t;
    typedef logic [MAX_WAYS-1:0]   way_vec_t;

    typedef struct packed {
        way_idx_t idx;
        logic     ok;
    } onehot_t;

    // Node n has children 2n+1 (left) and 2n+2 (right); a 0 bit means "go left".
    // Each step appends the taken direction, so the result is the leaf index.
    function automatic way_idx_t plru_victim(tree_t tree, int ways);
        int       node;
        int       levels;
        way_idx_t way;
        node   = 0;
        levels = $clog2(ways);
        way    = '0;
        for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
            if (lvl < levels) begin
                way  = {way[MAX_LEVELS-2:0], tree[node]};
                node = 2 * node + 1 + int'(tree[node]);
            end
        end
        return way;
    endfunction

    // The way's index bits, MSB first, give the path from the root. Each node
    // on that path is set to point into the sibling subtree.
    function automatic tree_t plru_update(tree_t tree, way_idx_t way, int ways);
        tree_t t;
        int    node;
        int    levels;
        logic  dir;
        t      = tree;
        node   = 0;
        levels = $clog2(ways);
        for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
            if (lvl < levels) begin
                dir     = way[levels-1-lvl];
                t[node] = ~dir;
                node    = 2 * node + 1 + int'(dir);
            end
        end
        return t;
    endfunction

    function automatic onehot_t onehot2idx(way_vec_t vec);
        onehot_t r;
        int      count;
        r.idx = '0;
        count = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (vec[i]) begin
                r.idx = way_idx_t'(i);
                count++;
            end
        end
        r.ok = (count == 1);
        return r;
    endfunction

endpackage

// File: rtl/tree_plru_calc.sv
// ---------------------------------------------------------------------------
// tree_plru_calc
// Combinational core: given one set's tree bits and the request, produce the
// result way, the error flag and the tree value that a state update would
// write. Whether that value is actually written is decided by the caller.
// Ports:
//   tree      in   WAYS-1  current tree bits of the addressed set
//   hit_sig   in   1       1 = hit, 0 = miss
//   hit_way   in   WAYS    one-hot hit way (ignored on a miss)
//   way       out  WAY_W   hit index, victim index, or 0 on error
//   err       out  1       hit whose hit_way is not exactly one-hot
//   next_tree out  WAYS-1  tree bits with 'way' marked most-recently-used
// ---------------------------------------------------------------------------
module tree_plru_calc
    import tree_plru_pkg::*;
#(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree,
    input  logic             hit_sig,
    input  logic [WAYS-1:0]  hit_way,
    output logic [WAY_W-1:0] way,
    output logic             err,
    output logic [WAYS-2:0]  next_tree
);

    tree_t    tree_wide;
    tree_t    next_wide;
    way_vec_t hit_wide;
    onehot_t  hit_dec;
    way_idx_t way_wide;
    logic     unused_bits;

    // Widen to the package's fixed sizes, pick the result way, then derive
    // the updated tree for that way.
    always_comb begin
        tree_wide              = '0;
        tree_wide[WAYS-2:0]    = tree;
        hit_wide               = '0;
        hit_wide[WAYS-1:0]     = hit_way;
        hit_dec                = onehot2idx(hit_wide);
        err                    = hit_sig & ~hit_dec.ok;
        if (!hit_sig) begin
            way_wide = plru_victim(tree_wide, WAYS);
        end else if (hit_dec.ok) begin
            way_wide = hit_dec.idx;
        end else begin
            way_wide = '0;
        end
        next_wide = plru_update(tree_wide, way_wide, WAYS);
    end

    assign way       = way_wide[WAY_W-1:0];
    assign next_tree = next_wide[WAYS-2:0];

    // Upper bits of the widened values are always zero for small WAYS.
    assign unused_bits = ^{next_wide, way_wide};

endmodule

// File: rtl/tree_plru_engine.sv
// ---------------------------------------------------------------------------
// tree_plru_engine
// Tree pseudo-LRU replacement engine for a WAYS-way, SETS-set cache with a
// valid/ready request side and a one-deep registered result.
// Optional feature macro: TREE_PLRU_STATS_EN (hit/miss counters).
// Ports:
//   clk          in   1      clock
//   rst          in   1      asynchronous active-low reset
//   i_valid      in   1      request valid
//   o_ready      out  1      request can be accepted this cycle
//   i_addr       in   SET_W  set index
//   i_hit_sig    in   1      1 = hit (i_hit_way), 0 = miss (victim wanted)
//   i_hit_way    in   WAYS   one-hot hit way
//   i_upd_en     in   1      1 = write the updated tree, 0 = lookup only
//   o_valid      out  1      result valid
//   i_ready      in   1      consumer takes the result
//   o_way        out  WAY_W  hit or victim way index
//   o_err        out  1      hit with zero or multi-hot i_hit_way
//   i_stats_clr  in   1      (STATS) synchronous clear of both counters
//   o_hit_cnt    out  32     (STATS) saturating count of good hits
//   o_miss_cnt   out  32     (STATS) saturating count of misses
// ---------------------------------------------------------------------------
module tree_plru_engine
    import tree_plru_pkg::*;
#(
    parameter  int WAYS  = 8,
    parameter  int SETS  = 128,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [SET_W-1:0] i_addr,
    input  logic             i_hit_sig,
    input  logic [WAYS-1:0]  i_hit_way,
    input  logic             i_upd_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WAY_W-1:0] o_way,
    output logic             o_err
`ifdef TREE_PLRU_STATS_EN
    ,
    input  logic             i_stats_clr,
    output logic [31:0]      o_hit_cnt,
    output logic [31:0]      o_miss_cnt
`endif
);

    logic [WAYS-2:0]  tree_mem [SETS];
    logic [WAYS-2:0]  cur_tree;
    logic [WAYS-2:0]  nxt_tree;
    logic [WAY_W-1:0] calc_way;
    logic             calc_err;
    logic             accept;

    assign o_ready  = ~o_valid | i_ready;
    assign accept   = i_valid & o_ready;
    assign cur_tree = tree_mem[i_addr];

    tree_plru_calc #(
        .WAYS (WAYS)
    ) u_calc (
        .tree      (cur_tree),
        .hit_sig   (i_hit_sig),
        .hit_way   (i_hit_way),
        .way       (calc_way),
        .err       (calc_err),
        .next_tree (nxt_tree)
    );

    // Tree state is written on the accept edge, so a request in the very next
    // cycle to the same set already reads the new bits without forwarding.
    // Error hits never touch the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                tree_mem[s] <= '0;
            end
        end else if (accept && i_upd_en && !calc_err) begin
            tree_mem[i_addr] <= nxt_tree;
        end
    end

    // One-deep result register: loads on accept, holds while stalled,
    // empties when the consumer takes it with nothing new arriving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_way   <= '0;
            o_err   <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_way   <= calc_way;
            o_err   <= calc_err;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef TREE_PLRU_STATS_EN
    // Counters track every accepted request, lookup-only included; error hits
    // count as neither. Clear takes priority and both stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (i_stats_clr) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (accept) begin
            if (i_hit_sig && !calc_err && o_hit_cnt != 32'hFFFF_FFFF) begin
                o_hit_cnt <= o_hit_cnt + 32'd1;
            end
            if (!i_hit_sig && o_miss_cnt != 32'hFFFF_FFFF) begin
                o_miss_cnt <= o_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tree_plru_engine.sv
// ---------------------------------------------------------------------------
// tb_tree_plru_engine
// Directed self-checking bench for tree_plru_engine (WAYS=8, SETS=128).
// Expected results come from a reference tree model and are queued when a
// request is accepted, then popped when the result appears.
// Define TREE_PLRU_STATS_EN to also exercise the hit/miss counters.
// ---------------------------------------------------------------------------
module tb_tree_plru_engine;

    localparam int WAYS  = 8;
    localparam int SETS  = 128;
    localparam int WAY_W = 3;
    localparam int SET_W = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [SET_W-1:0] i_addr = '0;
    logic             i_hit_sig = 1'b0;
    logic [WAYS-1:0]  i_hit_way = '0;
    logic             i_upd_en = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [WAY_W-1:0] o_way;
    logic             o_err;
`ifdef TREE_PLRU_STATS_EN
    logic             i_stats_clr = 1'b0;
    logic [31:0]      o_hit_cnt;
    logic [31:0]      o_miss_cnt;
`endif

    typedef struct packed {
        logic             err;
        logic [WAY_W-1:0] way;
    } exp_t;

    exp_t            exp_q[$];
    logic [WAYS-2:0] model_tree [SETS];
    int              checks = 0;
    int              errors = 0;
    int              seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

    tree_plru_engine #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_addr      (i_addr),
        .i_hit_sig   (i_hit_sig),
        .i_hit_way   (i_hit_way),
        .i_upd_en    (i_upd_en),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_way       (o_way),
        .o_err       (o_err)
`ifdef TREE_PLRU_STATS_EN
        ,
        .i_stats_clr (i_stats_clr),
        .o_hit_cnt   (o_hit_cnt),
        .o_miss_cnt  (o_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference victim: the bit read at each level is the next index bit.
    function automatic logic [WAY_W-1:0] mVictim(input logic [WAYS-2:0] t);
        int               node;
        logic [WAY_W-1:0] w;
        node = 0;
        w    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w    = {w[WAY_W-2:0], t[node]};
            node = 2 * node + 1 + int'(t[node]);
        end
        return w;
    endfunction

    // Reference update: the node at level l on the way's path is
    // (2^l - 1) + (top l bits of the way); it points away from the way.
    function automatic logic [WAYS-2:0] mUpdate(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        int              node;
        r = t;
        for (int l = 0; l < WAY_W; l++) begin
            node    = ((1 << l) - 1) + (int'(w) >> (WAY_W - l));
            r[node] = ~w[WAY_W-1-l];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < SETS; s++) begin
            model_tree[s] = '0;
        end
        exp_q.delete();
    endtask

    task automatic modelAccept(input logic [SET_W-1:0] addr, input logic hs,
                               input logic [WAYS-1:0] hw, input logic upd);
        exp_t e;
        int   cnt;
        int   idx;
        cnt = 0;
        idx = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (hw[i]) begin
                cnt++;
                idx = i;
            end
        end
        if (hs && cnt != 1) begin
            e.err = 1'b1;
            e.way = '0;
        end else begin
            e.err = 1'b0;
            e.way = hs ? WAY_W'(idx) : mVictim(model_tree[addr]);
            if (upd) begin
                model_tree[addr] = mUpdate(model_tree[addr], e.way);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request and hold it until the DUT accepts it (bounded).
    task automatic applyStimulus(input logic [SET_W-1:0] addr, input logic hs,
                                 input logic [WAYS-1:0] hw, input logic upd);
        logic accepted;
        accepted  = 1'b0;
        i_valid   = 1'b1;
        i_addr    = addr;
        i_hit_sig = hs;
        i_hit_way = hw;
        i_upd_en  = upd;
        for (int c = 0; c < 16 && !accepted; c++) begin
            if (o_ready) begin
                modelAccept(addr, hs, hw, upd);
                accepted = 1'b1;
            end
            step(1);
        end
        if (!accepted) begin
            check("accept_timeout", 32'(accepted), 32'd1);
        end
        i_valid = 1'b0;
    endtask

    // Compare the result currently presented against the scoreboard head.
    task automatic checkOutput(input string tag);
        exp_t e;
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_way"}, 32'(o_way), 32'(e.way));
            check({tag, "_err"}, 32'(o_err), 32'(e.err));
        end
    endtask

    task automatic doReq(input string tag, input logic [SET_W-1:0] addr, input logic hs,
                         input logic [WAYS-1:0] hw, input logic upd);
        applyStimulus(addr, hs, hw, upd);
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        step(2);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_way", 32'(o_way), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check("rst_ready", 32'(o_ready), 32'd1);

        // Test 1: repeated misses to set 0 walk the full PLRU order.
        for (int i = 0; i < 9; i++) begin
            doReq("t1", 7'd0, 1'b0, 8'h00, 1'b1);
            check("t1_seq", 32'(o_way), 32'(seq[i]));
        end

        // Test 2: a hit redirects the victim path; other sets untouched.
        doReq("t2_miss", 7'd5, 1'b0, 8'h00, 1'b1);
        check("t2_first", 32'(o_way), 32'd0);
        doReq("t2_hit", 7'd5, 1'b1, 8'b0001_0000, 1'b1);
        check("t2_hitidx", 32'(o_way), 32'd4);
        doReq("t2_miss2", 7'd5, 1'b0, 8'h00, 1'b1);
        check("t2_victim", 32'(o_way), 32'd2);
        doReq("t2_set6", 7'd6, 1'b0, 8'h00, 1'b1);
        check("t2_set6way", 32'(o_way), 32'd0);

        // Test 3: lookup-only requests leave the state alone.
        doReq("t3_look1", 7'd3, 1'b0, 8'h00, 1'b0);
        check("t3_w1", 32'(o_way), 32'd0);
        doReq("t3_look2", 7'd3, 1'b0, 8'h00, 1'b0);
        check("t3_w2", 32'(o_way), 32'd0);
        doReq("t3_upd", 7'd3, 1'b0, 8'h00, 1'b1);
        check("t3_w3", 32'(o_way), 32'd0);

        // Test 4: malformed hit vectors flag an error and do not update.
        doReq("t4_prime", 7'd7, 1'b0, 8'h00, 1'b1);
        doReq("t4_zero", 7'd7, 1'b1, 8'b0000_0000, 1'b1);
        check("t4_zero_err", 32'(o_err), 32'd1);
        doReq("t4_multi", 7'd7, 1'b1, 8'b0001_1000, 1'b1);
        check("t4_multi_err", 32'(o_err), 32'd1);
        check("t4_multi_way", 32'(o_way), 32'd0);
        doReq("t4_after", 7'd7, 1'b0, 8'h00, 1'b1);
        check("t4_after_way", 32'(o_way), 32'd4);

        // Test 5: back-pressure holds the result and stalls the next request.
        step(1);
        i_ready = 1'b0;
        applyStimulus(7'd10, 1'b0, 8'h00, 1'b1);
        i_valid   = 1'b1;
        i_addr    = 7'd10;
        i_hit_sig = 1'b0;
        i_hit_way = 8'h00;
        i_upd_en  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t5_ready_low", 32'(o_ready), 32'd0);
            check("t5_held_valid", 32'(o_valid), 32'd1);
            check("t5_held_way", 32'(o_way), 32'd0);
            step(1);
        end
        i_ready = 1'b1;
        #1;
        check("t5_ready_high", 32'(o_ready), 32'd1);
        checkOutput("t5_a");
        modelAccept(7'd10, 1'b0, 8'h00, 1'b1);
        step(1);
        i_valid = 1'b0;
        checkOutput("t5_b");
        check("t5_b_way", 32'(o_way), 32'd4);

        // Test 6: reset with a result pending drops it at once.
        step(1);
        i_ready = 1'b0;
        applyStimulus(7'd11, 1'b0, 8'h00, 1'b1);
        check("t6_pending", 32'(o_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(o_valid), 32'd0);
        check("t6_rst_way", 32'(o_way), 32'd0);
        modelReset();
        i_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        step(1);
        doReq("t6_s0", 7'd0, 1'b0, 8'h00, 1'b1);
        check("t6_s0_way", 32'(o_way), 32'd0);
        doReq("t6_s5", 7'd5, 1'b0, 8'h00, 1'b1);
        check("t6_s5_way", 32'(o_way), 32'd0);
        doReq("t6_s7", 7'd7, 1'b0, 8'h00, 1'b1);
        check("t6_s7_way", 32'(o_way), 32'd0);
        doReq("t6_s10", 7'd10, 1'b0, 8'h00, 1'b1);
        check("t6_s10_way", 32'(o_way), 32'd0);

`ifdef TREE_PLRU_STATS_EN
        i_stats_clr = 1'b1;
        step(1);
        i_stats_clr = 1'b0;
        check("st_clr0_hit", o_hit_cnt, 32'd0);
        check("st_clr0_miss", o_miss_cnt, 32'd0);
        doReq("st_h1", 7'd20, 1'b1, 8'h01, 1'b1);
        doReq("st_h2", 7'd20, 1'b1, 8'h80, 1'b1);
        doReq("st_h3", 7'd21, 1'b1, 8'h04, 1'b0);
        doReq("st_m1", 7'd20, 1'b0, 8'h00, 1'b1);
        doReq("st_m2", 7'd21, 1'b0, 8'h00, 1'b0);
        doReq("st_err", 7'd22, 1'b1, 8'h03, 1'b1);
        check("st_hit_cnt", o_hit_cnt, 32'd3);
        check("st_miss_cnt", o_miss_cnt, 32'd2);
        i_stats_clr = 1'b1;
        step(1);
        i_stats_clr = 1'b0;
        check("st_clr_hit", o_hit_cnt, 32'd0);
        check("st_clr_miss", o_miss_cnt, 32'd0);
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
